// File: rtl/ant_world.sv
// Ant walking an 8x8 walled arena: one action committed every STEP_CYC cycles,
// with a per-cell pheromone map and combinational wall sensors around the ant.
`ifndef PH_WIDTH
`define PH_WIDTH 4
`endif
`ifndef HALT
`define HALT 2'd0
`endif
`ifndef RIGHT
`define RIGHT 2'd1
`endif
`ifndef LEFT
`define LEFT 2'd2
`endif
`ifndef FORWARD
`define FORWARD 2'd3
`endif

module ant_world #(
    parameter int unsigned STEP_CYC  = 4,
    parameter logic [2:0]  START_X   = 3'd0,
    parameter logic [2:0]  START_Y   = 3'd0,
    parameter logic [1:0]  START_DIR = 2'd1,
    parameter logic [2:0]  EXIT_X    = 3'd7,
    parameter logic [2:0]  EXIT_Y    = 3'd7,
    parameter logic [63:0] WALL_MAP  = 64'h0,
    parameter int unsigned MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           move,
    input  logic [`PH_WIDTH-1:0] ph_drop,
    output logic                 ant_l,
    output logic                 ant_r,
    output logic                 hit,
    output logic                 escape,
    output logic [`PH_WIDTH-1:0] ph_detected,
    output logic [2:0]           pos_x,
    output logic [2:0]           pos_y,
    output logic [1:0]           heading,
    output logic [15:0]          step_cnt,
    output logic [15:0]          hit_cnt,
    output logic                 timeout
);
    localparam int unsigned     CntW    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYC - 1);

    // Neighbour cell as {x, y}, each 5 bits so that -1 and 8 stay distinguishable.
    function automatic logic [9:0] step_cell(input logic [2:0] x, input logic [2:0] y,
                                             input logic [1:0] dir);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = {2'b00, x};
        ny = {2'b00, y};
        unique case (dir)
            2'd0:    ny = ny - 5'd1;
            2'd1:    nx = nx + 5'd1;
            2'd2:    ny = ny + 5'd1;
            default: nx = nx - 5'd1;
        endcase
        return {nx, ny};
    endfunction

    // -1 wraps to 5'b11111 and 8 is 5'b01000: any upper bit set means off-grid.
    function automatic logic cell_blocked(input logic [9:0] c);
        return (c[9:8] != 2'b00) || (c[4:3] != 2'b00) || WALL_MAP[{c[2:0], c[7:5]}];
    endfunction

    logic [CntW-1:0]        cyc_q, cyc_d;
    logic [2:0]             pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]             dir_q, dir_d;
    logic [15:0]            step_q, step_d, hit_q, hit_d;
    logic                   timeout_q, timeout_d;
    logic [`PH_WIDTH-1:0]   ph_map_q [64];
    logic                   map_we;
    logic [5:0]             cur_idx;
    logic [9:0]             ahead_c;
    logic                   commit, frozen;

    assign commit  = (cyc_q == CntLast);
    assign cur_idx = {pos_y_q, pos_x_q};
    assign ahead_c = step_cell(pos_x_q, pos_y_q, dir_q);

    assign hit         = cell_blocked(ahead_c);
    assign ant_l       = cell_blocked(step_cell(pos_x_q, pos_y_q, dir_q - 2'd1));
    assign ant_r       = cell_blocked(step_cell(pos_x_q, pos_y_q, dir_q + 2'd1));
    assign escape      = (pos_x_q == EXIT_X) && (pos_y_q == EXIT_Y);
    assign frozen      = escape || timeout_q;
    assign ph_detected = ph_map_q[cur_idx];

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign heading  = dir_q;
    assign step_cnt = step_q;
    assign hit_cnt  = hit_q;
    assign timeout  = timeout_q;

    always_comb begin
        cyc_d     = commit ? '0 : cyc_q + CntW'(1);
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        step_d    = step_q;
        hit_d     = hit_q;
        timeout_d = timeout_q;
        map_we    = 1'b0;
        if (commit && !frozen) begin
            map_we = 1'b1;
            case (move)
                `LEFT:  dir_d = dir_q - 2'd1;
                `RIGHT: dir_d = dir_q + 2'd1;
                `FORWARD: begin
                    if (hit) begin
                        hit_d = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
                    end else begin
                        pos_x_d = ahead_c[7:5];
                        pos_y_d = ahead_c[2:0];
                    end
                end
                default: ;
            endcase
            step_d = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
            if ({16'd0, step_d} >= MAX_STEPS) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            pos_x_q   <= START_X;
            pos_y_q   <= START_Y;
            dir_q     <= START_DIR;
            step_q    <= '0;
            hit_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            hit_q     <= hit_d;
            timeout_q <= timeout_d;
        end
    end

    // The drop lands on the cell the ant occupied before this commit's move.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                ph_map_q[i] <= '0;
            end
        end else if (map_we) begin
            ph_map_q[cur_idx] <= ph_drop;
        end
    end

endmodule
